// File: rtl/screen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : screen_pkg
//  Description : Screen-select codes shared by the screen sequencer and the
//                VGA output mux, plus the width of the select bus.
//  Revision    : 1.0  initial release
// ============================================================================
package screen_pkg;

    // Width of the screen-select bus driven to the VGA mux
    localparam int SCR_W = 4;

    // Screen-select codes; anything from 5 upward is never driven
    localparam logic [SCR_W-1:0] SCR_OFF   = 4'd0;
    localparam logic [SCR_W-1:0] SCR_INTRO = 4'd1;
    localparam logic [SCR_W-1:0] SCR_MENU  = 4'd2;
    localparam logic [SCR_W-1:0] SCR_GAME  = 4'd3;
    localparam logic [SCR_W-1:0] SCR_SCORE = 4'd4;

    // True for the five codes that correspond to a real screen
    function automatic logic scr_is_legal(input logic [SCR_W-1:0] code);
        return (code <= SCR_SCORE);
    endfunction

endpackage : screen_pkg
`default_nettype wire

// File: rtl/screen_sequencer_edge_latch.sv
`default_nettype none
// ============================================================================
//  Module      : edge_latch
//  Description : Rising-edge detector with a sticky pending flag. The flag is
//                cleared by i_clear; an edge arriving in the clear cycle is
//                still reported on o_pending for that cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module edge_latch (
    input  logic clk,
    input  logic clr,
    input  logic i_btn,
    input  logic i_clear,
    output logic o_pending
);

    logic r_btn_q;
    logic r_pending;
    logic w_rise;

    assign w_rise    = i_btn & ~r_btn_q;
    // Same-cycle edge is visible immediately so the consumer can act on it
    assign o_pending = r_pending | w_rise;

    // Previous button level for edge detection
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= i_btn;
        end
    end

    // Sticky pending flag: set by an edge, dropped whenever a clear arrives
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pending <= 1'b0;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end else if (w_rise) begin
            r_pending <= 1'b1;
        end
    end

endmodule : edge_latch
`default_nettype wire

// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : screen_sequencer
//  Description : Display/game-flow controller. Walks off -> intro -> menu ->
//                game -> score on frame boundaries, drives the screen-select
//                code and intro blink flag, and gates/resets the game engine.
//  Revision    : 1.0  initial release
// ============================================================================
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int INTRO_FRAMES = 300,
    parameter int BLINK_FRAMES = 30,
    parameter int SCORE_FRAMES = 600,
    parameter int CNT_W        = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             frame_tick,
    input  logic             pwr_en,
    input  logic             btn_start,
    input  logic             btn_back,
    input  logic             game_over,
    output logic [SCR_W-1:0] vga_control,
    output logic             blink,
    output logic             game_en,
    output logic             game_rst
);

    // State encoding equals the screen code so the select bus needs no decode
    localparam logic [SCR_W-1:0] c_st_off   = SCR_OFF;
    localparam logic [SCR_W-1:0] c_st_intro = SCR_INTRO;
    localparam logic [SCR_W-1:0] c_st_menu  = SCR_MENU;
    localparam logic [SCR_W-1:0] c_st_game  = SCR_GAME;
    localparam logic [SCR_W-1:0] c_st_score = SCR_SCORE;

    // Last count value before each timeout fires; counters never reach wrap
    localparam logic [CNT_W-1:0] c_intro_last = CNT_W'(INTRO_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_score_last = CNT_W'(SCORE_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_blink_last = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    logic [SCR_W-1:0] r_state;
    logic [SCR_W-1:0] w_state_next;
    logic             w_state_change;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink;
    logic             r_game_rst;
    logic             w_start_pend;
    logic             w_back_pend;

    // Button edge capture; both flags are consumed on every frame tick
    edge_latch u_start_latch (
        .clk       (clk),
        .clr       (clr),
        .i_btn     (btn_start),
        .i_clear   (frame_tick),
        .o_pending (w_start_pend)
    );

    edge_latch u_back_latch (
        .clk       (clk),
        .clr       (clr),
        .i_btn     (btn_back),
        .i_clear   (frame_tick),
        .o_pending (w_back_pend)
    );

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= c_st_off;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: legal states move only on a frame tick, power-off wins
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_off: begin
                if (frame_tick && pwr_en) begin
                    w_state_next = c_st_intro;
                end
            end
            c_st_intro: begin
                if (frame_tick) begin
                    if (!pwr_en) begin
                        w_state_next = c_st_off;
                    end else if (w_start_pend || (r_frame_cnt == c_intro_last)) begin
                        w_state_next = c_st_menu;
                    end
                end
            end
            c_st_menu: begin
                if (frame_tick) begin
                    if (!pwr_en) begin
                        w_state_next = c_st_off;
                    end else if (w_start_pend) begin
                        w_state_next = c_st_game;
                    end else if (w_back_pend) begin
                        w_state_next = c_st_intro;
                    end
                end
            end
            c_st_game: begin
                if (frame_tick) begin
                    if (!pwr_en) begin
                        w_state_next = c_st_off;
                    end else if (game_over) begin
                        w_state_next = c_st_score;
                    end else if (w_back_pend) begin
                        w_state_next = c_st_menu;
                    end
                end
            end
            c_st_score: begin
                if (frame_tick) begin
                    if (!pwr_en) begin
                        w_state_next = c_st_off;
                    end else if (w_start_pend || (r_frame_cnt == c_score_last)) begin
                        w_state_next = c_st_menu;
                    end
                end
            end
            // Corrupted state register recovers straight away
            default: w_state_next = c_st_off;
        endcase
    end

    assign w_state_change = (w_state_next != r_state);

    // Frame and blink counters: cleared on any state change, advanced per tick
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
        end else if (w_state_change) begin
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
        end else if (frame_tick) begin
            if (r_state == c_st_intro) begin
                r_frame_cnt <= r_frame_cnt + c_cnt_one;
                if (r_blink_cnt == c_blink_last) begin
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_cnt_one;
                end
            end else if (r_state == c_st_score) begin
                r_frame_cnt <= r_frame_cnt + c_cnt_one;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= '0;
            end
        end
    end

    // Blink flag toggles at the end of each half-period, held low off-intro
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_blink <= 1'b0;
        end else if (w_state_change || (r_state != c_st_intro)) begin
            r_blink <= 1'b0;
        end else if (frame_tick && (r_blink_cnt == c_blink_last)) begin
            r_blink <= ~r_blink;
        end
    end

    // Game reset pulse lines up with the first cycle the select reads GAME
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_game_rst <= 1'b0;
        end else begin
            r_game_rst <= w_state_change && (w_state_next == c_st_game);
        end
    end

    // Output decode from registered state; illegal codes never leave the block
    always_comb begin
        vga_control = scr_is_legal(r_state) ? r_state : SCR_OFF;
        game_en     = (r_state == c_st_game);
        blink       = r_blink;
        game_rst    = r_game_rst;
    end

endmodule : screen_sequencer
`default_nettype wire
